// File: rtl/jtcop_snd_romarb.sv
// Sound ROM arbiter: one-word cache per port (CPU, ADPCM) in front of a shared SDRAM slot.
// Latency: cache hit returns ok in the same cycle; a miss returns ok the cycle after mem_ok.
// Backpressure: mem_cs is held with a stable address until mem_ok; requesters wait with cs high.
module jtcop_snd_romarb #(
  parameter int                 CPU_AW     = 16,
  parameter int                 PCM_AW     = 18,
  parameter int                 SLOT_AW    = 21,
  parameter logic [SLOT_AW-1:0] CPU_OFFSET = 21'h0,
  parameter logic [SLOT_AW-1:0] PCM_OFFSET = 21'h10000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_cs,
  input  logic [CPU_AW-1:0]  cpu_addr,
  input  logic               cpu_flush,
  output logic [7:0]         cpu_data,
  output logic               cpu_ok,
  input  logic               pcm_cs,
  input  logic [PCM_AW-1:0]  pcm_addr,
  output logic [7:0]         pcm_data,
  output logic               pcm_ok,
  output logic               mem_cs,
  output logic [SLOT_AW-1:0] mem_addr,
  input  logic [15:0]        mem_data,
  input  logic               mem_ok
);

  typedef enum logic [1:0] {IDLE, CPU_WAIT, PCM_WAIT} state_t;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_PCM = 1'b1;

  state_t               state_q, state_d;
  logic                 mem_cs_q, mem_cs_d;
  logic [SLOT_AW-1:0]   mem_addr_q, mem_addr_d;
  logic                 last_grant_q, last_grant_d;
  logic                 cpu_valid_q, cpu_valid_d;
  logic [CPU_AW-2:0]    cpu_tag_q, cpu_tag_d;
  logic [CPU_AW-2:0]    cpu_ltag_q, cpu_ltag_d;
  logic [15:0]          cpu_word_q, cpu_word_d;
  logic                 cpu_fl_q, cpu_fl_d;
  logic                 pcm_valid_q, pcm_valid_d;
  logic [PCM_AW-2:0]    pcm_tag_q, pcm_tag_d;
  logic [PCM_AW-2:0]    pcm_ltag_q, pcm_ltag_d;
  logic [15:0]          pcm_word_q, pcm_word_d;
  logic                 cpu_miss, pcm_miss;

  // Cache lookup: ok and data come straight from the cache registers
  always_comb begin
    cpu_ok   = cpu_cs & cpu_valid_q & (cpu_tag_q == cpu_addr[CPU_AW-1:1]);
    pcm_ok   = pcm_cs & pcm_valid_q & (pcm_tag_q == pcm_addr[PCM_AW-1:1]);
    cpu_miss = cpu_cs & ~cpu_ok;
    pcm_miss = pcm_cs & ~pcm_ok;
    cpu_data = cpu_addr[0] ? cpu_word_q[15:8] : cpu_word_q[7:0];
    pcm_data = pcm_addr[0] ? pcm_word_q[15:8] : pcm_word_q[7:0];
    mem_cs   = mem_cs_q;
    mem_addr = mem_addr_q;
  end

  // Arbitration and fill sequencing; a flush seen during a CPU fill keeps that fill invalid
  always_comb begin
    state_d      = state_q;
    mem_cs_d     = mem_cs_q;
    mem_addr_d   = mem_addr_q;
    last_grant_d = last_grant_q;
    cpu_valid_d  = cpu_valid_q & ~cpu_flush;
    cpu_tag_d    = cpu_tag_q;
    cpu_ltag_d   = cpu_ltag_q;
    cpu_word_d   = cpu_word_q;
    cpu_fl_d     = cpu_fl_q | ((state_q == CPU_WAIT) & cpu_flush);
    pcm_valid_d  = pcm_valid_q;
    pcm_tag_d    = pcm_tag_q;
    pcm_ltag_d   = pcm_ltag_q;
    pcm_word_d   = pcm_word_q;
    case (state_q)
      IDLE: begin
        // CPU wins when alone or when PCM had the previous grant
        if (cpu_miss && (!pcm_miss || last_grant_q == GNT_PCM)) begin
          state_d      = CPU_WAIT;
          mem_cs_d     = 1'b1;
          mem_addr_d   = CPU_OFFSET + SLOT_AW'(cpu_addr[CPU_AW-1:1]);
          cpu_ltag_d   = cpu_addr[CPU_AW-1:1];
          last_grant_d = GNT_CPU;
          cpu_fl_d     = 1'b0;
        end else if (pcm_miss) begin
          state_d      = PCM_WAIT;
          mem_cs_d     = 1'b1;
          mem_addr_d   = PCM_OFFSET + SLOT_AW'(pcm_addr[PCM_AW-1:1]);
          pcm_ltag_d   = pcm_addr[PCM_AW-1:1];
          last_grant_d = GNT_PCM;
        end
      end
      CPU_WAIT: begin
        if (mem_ok) begin
          cpu_word_d  = mem_data;
          cpu_tag_d   = cpu_ltag_q;
          cpu_valid_d = ~(cpu_fl_q | cpu_flush);
          mem_cs_d    = 1'b0;
          state_d     = IDLE;
        end
      end
      PCM_WAIT: begin
        if (mem_ok) begin
          pcm_word_d  = mem_data;
          pcm_tag_d   = pcm_ltag_q;
          pcm_valid_d = 1'b1;
          mem_cs_d    = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        mem_cs_d = 1'b0;
      end
    endcase
  end

  // State registers; reset leaves last_grant at PCM so the CPU wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mem_cs_q     <= 1'b0;
      mem_addr_q   <= '0;
      last_grant_q <= GNT_PCM;
      cpu_valid_q  <= 1'b0;
      cpu_tag_q    <= '0;
      cpu_ltag_q   <= '0;
      cpu_word_q   <= '0;
      cpu_fl_q     <= 1'b0;
      pcm_valid_q  <= 1'b0;
      pcm_tag_q    <= '0;
      pcm_ltag_q   <= '0;
      pcm_word_q   <= '0;
    end else begin
      state_q      <= state_d;
      mem_cs_q     <= mem_cs_d;
      mem_addr_q   <= mem_addr_d;
      last_grant_q <= last_grant_d;
      cpu_valid_q  <= cpu_valid_d;
      cpu_tag_q    <= cpu_tag_d;
      cpu_ltag_q   <= cpu_ltag_d;
      cpu_word_q   <= cpu_word_d;
      cpu_fl_q     <= cpu_fl_d;
      pcm_valid_q  <= pcm_valid_d;
      pcm_tag_q    <= pcm_tag_d;
      pcm_ltag_q   <= pcm_ltag_d;
      pcm_word_q   <= pcm_word_d;
    end
  end

endmodule
